// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W payload bits LSB first, optional even parity, and a stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_valid) begin
                    state_d = S_START;
                    shift_d = tx_data;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                // Shift at every bit boundary so the next bit is always at shift_d[0].
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Line level is computed from the next state so tx changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = (state_q == S_IDLE);
    assign busy     = ~tx_ready;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx at CLKS_PER_BIT=4, DATA_W=8; parity cases run when SERIAL_TX_PARITY_EN is defined.
module tb_serial_tx;

    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       clk_en;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int n_cmp;
    int n_fail;

    serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "watchdog");
    end

    // Called at 1 time unit after a posedge; performs the handshake on the next posedge.
    task automatic send(input logic [7:0] d, input string name);
        tx_data  = d;
        tx_valid = 1'b1;
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s pre-handshake ready: got %b, required 1", name, tx_ready);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    // Called 1 time unit after the handshake edge; checks every cycle of the frame.
    task automatic check_frame(input logic [7:0] d, input string name);
        logic [10:0] exp;
`ifdef SERIAL_TX_PARITY_EN
        exp = {1'b1, ^d, d, 1'b0};
`else
        exp = {1'b0, 1'b1, d, 1'b0};
`endif
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
                n_cmp++;
                if (tx !== exp[b] || tx_ready !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s bit%0d cyc%0d: tx=%b ready=%b busy=%b, required tx=%b ready=0 busy=1",
                             name, b, c, tx, tx_ready, busy, exp[b]);
                end
                @(posedge clk); #1;
            end
        end
        n_cmp++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end-of-frame: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0",
                     name, tx, tx_ready, busy);
        end
    endtask

    task automatic test_reset();
        clk_en   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        reset    = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_noclk: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0", tx, tx_ready, busy);
        end
        #20;
        n_cmp++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0", tx, tx_ready, busy);
        end
        reset  = 1'b1;
        clk_en = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (tx !== 1'b1 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: tx=%b ready=%b, required tx=1 ready=1", tx, tx_ready);
        end
    endtask

    task automatic test_single();
        send(8'hA5, "a5");
        check_frame(8'hA5, "a5");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'hC3;
        check_frame(8'h3C, "b2b_first");
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check_frame(8'hC3, "b2b_second");
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        send(8'hFF, "abort_pre");
        repeat (16) @(posedge clk);
        #1;
        n_cmp++;
        if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_midframe busy: ready=%b, required 0", tx_ready);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0", tx, tx_ready, busy);
        end
        #1 reset = 1'b1;
        send(8'h55, "abort_55");
        check_frame(8'h55, "abort_55");
        @(posedge clk); #1;
    endtask

    task automatic test_data_hold();
        send(8'hFF, "hold");
        tx_data = 8'h00;
        check_frame(8'hFF, "hold");
        @(posedge clk); #1;
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        send(8'h07, "par07");
        repeat (9 * CPB) @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL par07 parity bit: tx=%b, required 1", tx);
        end
        repeat (2 * CPB) @(posedge clk);
        #1;
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL par07 length: ready=%b after 44 cycles, required 1", tx_ready);
        end
        @(posedge clk); #1;
        send(8'h03, "par03");
        repeat (9 * CPB) @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL par03 parity bit: tx=%b, required 0", tx);
        end
        repeat (2 * CPB) @(posedge clk);
        #1;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_data_hold();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
